// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-drive and response signals of the ALU op sequencer.
// The slave modport is the sequencer side; master is its environment.
interface alu_op_sequencer_if;
  logic        reqValid;
  logic        reqReady;
  logic [2:0]  reqOp;
  logic [31:0] reqSrc1;
  logic [31:0] reqSrc2;
  logic [2:0]  aluCntrl;
  logic [31:0] aluSrc1;
  logic [31:0] aluSrc2;
  logic [63:0] aluOut;
  logic        carryOut;
  logic        rspValid;
  logic        rspReady;
  logic [63:0] rspData;
  logic        rspCarry;
  logic        rspDivZero;
  logic        rspErr;
  logic        busy;

  modport slave (
    input  reqValid, reqOp, reqSrc1, reqSrc2, aluOut, carryOut, rspReady,
    output reqReady, aluCntrl, aluSrc1, aluSrc2, rspValid, rspData,
           rspCarry, rspDivZero, rspErr, busy
  );

  modport master (
    output reqValid, reqOp, reqSrc1, reqSrc2, aluOut, carryOut, rspReady,
    input  reqReady, aluCntrl, aluSrc1, aluSrc2, rspValid, rspData,
           rspCarry, rspDivZero, rspErr, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue stage for the 32-bit ALU: one op at a time, division done here as
// repeated subtraction through the ALU subtract op.
module alu_op_sequencer #(
  parameter int DIV_ITER_LIMIT = 1024
) (
  input logic               Clock,
  input logic               Reset_n,
  alu_op_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, CAPTURE, DIV_CHECK, DIV_SUB, DIV_CAP, RESP
  } state_t;

  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_DIV = 3'd3;

  state_t      state_reg, state_next;
  logic [2:0]  op_reg;
  logic [31:0] src1_reg, src2_reg, rem_reg, quo_reg;
  logic [63:0] rsp_data_reg;
  logic        rsp_carry_reg, rsp_div_zero_reg, rsp_err_reg;
  logic [2:0]  alu_cntrl;
  logic [31:0] alu_src1, alu_src2;
  logic        carry_op;
  logic        at_limit;

  assign carry_op = (op_reg == 3'd0) || (op_reg == 3'd1) ||
                    (op_reg == 3'd4) || (op_reg == 3'd5);
  assign at_limit = (quo_reg == 32'(DIV_ITER_LIMIT));

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // ALU inputs are decoded from state so they are valid during the issue
  // cycle itself; the ALU registers them on the edge leaving that state.
  always_comb begin
    state_next = state_reg;
    alu_cntrl  = 3'd0;
    alu_src1   = 32'd0;
    alu_src2   = 32'd0;
    case (state_reg)
      IDLE: begin
        if (bus.reqValid) begin
          if (bus.reqOp != OP_DIV)      state_next = ISSUE;
          else if (bus.reqSrc2 == 32'd0) state_next = RESP;
          else                           state_next = DIV_CHECK;
        end
      end
      ISSUE: begin
        alu_cntrl  = op_reg;
        alu_src1   = src1_reg;
        alu_src2   = src2_reg;
        state_next = CAPTURE;
      end
      CAPTURE: state_next = RESP;
      DIV_CHECK: begin
        if (rem_reg < src2_reg || at_limit) state_next = RESP;
        else                                state_next = DIV_SUB;
      end
      DIV_SUB: begin
        alu_cntrl  = OP_SUB;
        alu_src1   = rem_reg;
        alu_src2   = src2_reg;
        state_next = DIV_CAP;
      end
      DIV_CAP: state_next = DIV_CHECK;
      RESP: begin
        if (bus.rspReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      op_reg           <= 3'd0;
      src1_reg         <= 32'd0;
      src2_reg         <= 32'd0;
      rem_reg          <= 32'd0;
      quo_reg          <= 32'd0;
      rsp_data_reg     <= 64'd0;
      rsp_carry_reg    <= 1'b0;
      rsp_div_zero_reg <= 1'b0;
      rsp_err_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.reqValid) begin
            op_reg           <= bus.reqOp;
            src1_reg         <= bus.reqSrc1;
            src2_reg         <= bus.reqSrc2;
            rsp_carry_reg    <= 1'b0;
            rsp_div_zero_reg <= 1'b0;
            rsp_err_reg      <= 1'b0;
            if (bus.reqOp == OP_DIV) begin
              if (bus.reqSrc2 == 32'd0) begin
                rsp_data_reg     <= {bus.reqSrc1, 32'hFFFF_FFFF};
                rsp_div_zero_reg <= 1'b1;
              end else begin
                rem_reg <= bus.reqSrc1;
                quo_reg <= 32'd0;
              end
            end
          end
        end
        CAPTURE: begin
          rsp_data_reg  <= bus.aluOut;
          rsp_carry_reg <= carry_op ? bus.carryOut : 1'b0;
        end
        DIV_CHECK: begin
          // Limit is tested before any further subtract, so quo stops at it.
          if (rem_reg < src2_reg) begin
            rsp_data_reg <= {rem_reg, quo_reg};
          end else if (at_limit) begin
            rsp_data_reg <= {rem_reg, quo_reg};
            rsp_err_reg  <= 1'b1;
          end
        end
        DIV_CAP: begin
          rem_reg <= bus.aluOut[31:0];
          quo_reg <= quo_reg + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.reqReady   = (state_reg == IDLE);
  assign bus.rspValid   = (state_reg == RESP);
  assign bus.busy       = (state_reg != IDLE);
  assign bus.aluCntrl   = alu_cntrl;
  assign bus.aluSrc1    = alu_src1;
  assign bus.aluSrc2    = alu_src2;
  assign bus.rspData    = rsp_data_reg;
  assign bus.rspCarry   = rsp_carry_reg;
  assign bus.rspDivZero = rsp_div_zero_reg;
  assign bus.rspErr     = rsp_err_reg;

endmodule
